// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-side blocks: arbiter state encoding
// and default bus widths.
package cpu_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DM_ACC = 2'd1,
      IF_ACC = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arbiter_ack_timer.sv
// Per-access acknowledge watchdog. Counts cycles spent waiting for the memory
// and flags the cycle in which the wait budget is used up.
module ack_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;

   // Wait counter: clear dominates, saturates at TIMEOUT instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i)
         cnt_q <= '0;
      else if (en_i && (cnt_q != MAX))
         cnt_q <= cnt_q + CW'(1);
   end

   // Expired during the TIMEOUT-th waiting cycle, so the access lasts
   // exactly TIMEOUT cycles when no ack ever arrives.
   assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction
// fetch and data requesters. Both requests are sampled together, data is
// serviced first, and the pipeline is held until the whole bundle completes.
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              ready_o,
   output logic              stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              err_o
);

   state_t state_q, state_d;

   logic              dm_pend_q, if_pend_q;
   logic              dm_we_q;
   logic [ADDR_W-1:0] dm_addr_q, if_addr_q;
   logic [DATA_W-1:0] dm_wdata_q;

   logic in_acc;
   logic expired;
   logic acc_done;
   logic abort;

   // An access finishes on ack or on watchdog expiry; ack wins if both occur.
   assign acc_done = in_acc & (mem_ack_i | expired);
   assign abort    = in_acc & ~mem_ack_i & expired;

   ack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (~in_acc | acc_done),
      .en_i      (in_acc & ~mem_ack_i),
      .expired_o (expired)
   );

   // State register and pending flags; pending flags are taken only in IDLE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         dm_pend_q <= 1'b0;
         if_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            dm_pend_q <= dm_req_i;
            if_pend_q <= if_req_i;
         end
      end
   end

   // Request payload latches; only meaningful while the matching flag is set.
   always_ff @(posedge clk_i) begin
      if (state_q == IDLE) begin
         dm_we_q    <= dm_we_i;
         dm_addr_q  <= dm_addr_i;
         dm_wdata_q <= dm_wdata_i;
         if_addr_q  <= if_addr_i;
      end
   end

   // Next-state logic and memory-side / pipeline-side outputs.
   always_comb begin
      state_d      = state_q;
      in_acc       = 1'b0;
      stall_o      = 1'b0;
      ready_o      = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         IDLE: begin
            stall_o = if_req_i | dm_req_i;
            if (dm_req_i)
               state_d = DM_ACC;
            else if (if_req_i)
               state_d = IF_ACC;
         end
         DM_ACC: begin
            in_acc       = 1'b1;
            stall_o      = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = dm_we_q;
            mem_addr_o   = dm_addr_q;
            mem_data_o   = dm_wdata_q;
            if (mem_ack_i || expired)
               state_d = if_pend_q ? IF_ACC : RESP;
         end
         IF_ACC: begin
            in_acc       = 1'b1;
            stall_o      = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = if_addr_q;
            if (mem_ack_i || expired)
               state_d = RESP;
         end
         RESP: begin
            ready_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result capture and sticky error. An aborted read returns 0; a write
   // never touches dm_rdata_o, aborted or not.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dm_rdata_o <= '0;
         if_data_o  <= '0;
         err_o      <= 1'b0;
      end else begin
         if ((state_q == DM_ACC) && acc_done && !dm_we_q)
            dm_rdata_o <= mem_ack_i ? mem_data_i : '0;
         if ((state_q == IF_ACC) && acc_done)
            if_data_o <= mem_ack_i ? mem_data_i : '0;
         if (abort)
            err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state memory responder.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_data, dm_rdata;
   logic        ready, stall, mem_enable, mem_write, mem_ack, err;
   logic [31:0] mem_addr, mem_data, mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   // Responder configuration: ack after wait_n wait states when ack_on.
   int   wait_n = 0;
   logic ack_on = 1'b0;
   int   acc_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_data_o    (if_data),
      .dm_req_i     (dm_req),
      .dm_we_i      (dm_we),
      .dm_addr_i    (dm_addr),
      .dm_wdata_i   (dm_wdata),
      .dm_rdata_o   (dm_rdata),
      .ready_o      (ready),
      .stall_o      (stall),
      .mem_enable_o (mem_enable),
      .mem_write_o  (mem_write),
      .mem_addr_o   (mem_addr),
      .mem_data_o   (mem_data),
      .mem_ack_i    (mem_ack),
      .mem_data_i   (mem_rdata),
      .err_o        (err)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h8)       return 32'h2008_0005;
      else if (a == 32'h80) return 32'h0000_1234;
      else                  return {16'hA5A5, a[15:0]};
   endfunction

   assign mem_ack   = mem_enable && ack_on && (acc_cnt == wait_n);
   assign mem_rdata = mem_rd(mem_addr);

   // Count cycles of the current access so ack lands after wait_n waits.
   always @(posedge clk) begin
      if (mem_enable && !mem_ack)
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic e_stall, input logic e_en,
                      input logic e_we, input logic [31:0] e_addr, input logic e_rdy);
      #1;
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
      chk({tag, ".en"},    {31'd0, mem_enable}, {31'd0, e_en});
      chk({tag, ".we"},    {31'd0, mem_write}, {31'd0, e_we});
      chk({tag, ".addr"},  mem_addr, e_addr);
      chk({tag, ".ready"}, {31'd0, ready}, {31'd0, e_rdy});
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      tick(); tick();
      cyc("rst", 0, 0, 0, 32'h0, 0);
      chk("rst.err", {31'd0, err}, 32'd0);
      chk("rst.if_data", if_data, 32'h0);
      chk("rst.dm_rdata", dm_rdata, 32'h0);
      chk("rst.mem_data", mem_data, 32'h0);

      // Fetch only, zero-wait
      rst = 1'b0; ack_on = 1'b1; wait_n = 0;
      if_req = 1'b1; if_addr = 32'h8;
      cyc("t1.idle", 1, 0, 0, 32'h0, 0);
      tick(); cyc("t1.acc", 1, 1, 0, 32'h8, 0);
      tick(); cyc("t1.resp", 0, 0, 0, 32'h0, 1);
      chk("t1.if_data", if_data, 32'h2008_0005);
      if_req = 1'b0;
      tick(); cyc("t1.after", 0, 0, 0, 32'h0, 0);

      // Simultaneous fetch and read, 2 wait states; inputs change after sampling
      wait_n = 2;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      if_req = 1'b1; if_addr = 32'hC;
      cyc("t2.idle", 1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 0) begin dm_addr = 32'h99; if_addr = 32'h77; end
         cyc("t2.dm", 1, 1, 0, 32'h40, 0);
      end
      for (int i = 0; i < 3; i++) begin
         tick(); cyc("t2.if", 1, 1, 0, 32'hC, 0);
      end
      tick(); cyc("t2.resp", 0, 0, 0, 32'h0, 1);
      chk("t2.dm_rdata", dm_rdata, 32'hA5A5_0040);
      chk("t2.if_data", if_data, 32'hA5A5_000C);
      dm_req = 1'b0; if_req = 1'b0;
      tick(); cyc("t2.after", 0, 0, 0, 32'h0, 0);

      // Data write
      wait_n = 0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
      cyc("t3.idle", 1, 0, 0, 32'h0, 0);
      tick(); cyc("t3.acc", 1, 1, 1, 32'h10, 0);
      chk("t3.wdata", mem_data, 32'hDEAD_BEEF);
      tick(); cyc("t3.resp", 0, 0, 0, 32'h0, 1);
      chk("t3.dm_rdata", dm_rdata, 32'hA5A5_0040);
      dm_req = 1'b0; dm_we = 1'b0;
      tick(); cyc("t3.after", 0, 0, 0, 32'h0, 0);

      // Timeout: no ack, abort after 4 access cycles
      ack_on = 1'b0;
      dm_req = 1'b1; dm_addr = 32'h20;
      cyc("t4.idle", 1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); cyc("t4.acc", 1, 1, 0, 32'h20, 0);
         chk("t4.err_wait", {31'd0, err}, 32'd0);
      end
      tick(); cyc("t4.resp", 0, 0, 0, 32'h0, 1);
      chk("t4.dm_rdata", dm_rdata, 32'h0);
      chk("t4.err", {31'd0, err}, 32'd1);
      dm_req = 1'b0;
      tick();
      ack_on = 1'b1; wait_n = 0;
      if_req = 1'b1; if_addr = 32'h8;
      cyc("t4b.idle", 1, 0, 0, 32'h0, 0);
      tick(); cyc("t4b.acc", 1, 1, 0, 32'h8, 0);
      tick(); cyc("t4b.resp", 0, 0, 0, 32'h0, 1);
      chk("t4b.if_data", if_data, 32'h2008_0005);
      chk("t4b.err_sticky", {31'd0, err}, 32'd1);
      if_req = 1'b0;
      tick();

      // Ack on the TIMEOUT cycle
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5.err_clr", {31'd0, err}, 32'd0);
      wait_n = 3;
      dm_req = 1'b1; dm_addr = 32'h80;
      cyc("t5.idle", 1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); cyc("t5.acc", 1, 1, 0, 32'h80, 0);
      end
      tick(); cyc("t5.resp", 0, 0, 0, 32'h0, 1);
      chk("t5.dm_rdata", dm_rdata, 32'h0000_1234);
      chk("t5.err", {31'd0, err}, 32'd0);
      dm_req = 1'b0;
      tick();

      // Reset mid-access
      wait_n = 5;
      dm_req = 1'b1; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h8;
      cyc("t6.idle", 1, 0, 0, 32'h0, 0);
      tick(); cyc("t6.acc", 1, 1, 0, 32'h40, 0);
      rst = 1'b1; dm_req = 1'b0; if_req = 1'b0;
      tick(); cyc("t6.rst", 0, 0, 0, 32'h0, 0);
      chk("t6.dm_rdata", dm_rdata, 32'h0);
      chk("t6.if_data", if_data, 32'h0);
      chk("t6.mem_data", mem_data, 32'h0);
      rst = 1'b0;
      tick(); cyc("t6.after", 0, 0, 0, 32'h0, 0);
      tick(); cyc("t6.after2", 0, 0, 0, 32'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
